// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one burst-oriented memory port between the I-cache
// line fill, D-cache line fill and D-cache line writeback request ports.
// Each grant runs a command phase, then a BURST_LEN-beat data phase, and only
// one transaction is ever outstanding.
// Build option: define ARB_ROUND_ROBIN_EN to replace the fixed
// dc_wr > dc_rd > ic priority with a rotating grant pointer.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    output logic [DATA_WIDTH-1:0] ic_rdata,
    output logic                  ic_rdata_valid,
    input  logic                  dc_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] dc_rd_req_addr,
    output logic                  dc_rd_req_ready,
    output logic [DATA_WIDTH-1:0] dc_rdata,
    output logic                  dc_rdata_valid,
    input  logic                  dc_wr_req_valid,
    input  logic [ADDR_WIDTH-1:0] dc_wr_req_addr,
    output logic                  dc_wr_req_ready,
    input  logic [DATA_WIDTH-1:0] dc_wr_data,
    input  logic                  dc_wr_data_valid,
    output logic                  dc_wr_data_ready,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_write,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wdata_valid,
    input  logic                  mem_wdata_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdata_valid
);

    localparam int CNT_W       = $clog2(BURST_LEN) + 1;
    localparam int LINE_OFFS_W = $clog2((DATA_WIDTH / 8) * BURST_LEN);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'((1 << LINE_OFFS_W) - 1));

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        RD_BURST = 2'd2,
        WR_BURST = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // One-hot grant: bit 0 = dc_wr, bit 1 = dc_rd, bit 2 = ic.
    logic [2:0]            gnt;
    logic [ADDR_WIDTH-1:0] sel_addr;

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer names the requester checked first: 0 = dc_wr, 1 = dc_rd, 2 = ic.
    logic [1:0] rr_q, rr_d;

    // Pick the first valid requester at or after the rotating pointer.
    always_comb begin
        gnt = 3'b000;
        if (rst_n && state_q == IDLE) begin
            case (rr_q)
                2'd1: begin
                    if (dc_rd_req_valid)      gnt = 3'b010;
                    else if (ic_req_valid)    gnt = 3'b100;
                    else if (dc_wr_req_valid) gnt = 3'b001;
                end
                2'd2: begin
                    if (ic_req_valid)         gnt = 3'b100;
                    else if (dc_wr_req_valid) gnt = 3'b001;
                    else if (dc_rd_req_valid) gnt = 3'b010;
                end
                default: begin
                    if (dc_wr_req_valid)      gnt = 3'b001;
                    else if (dc_rd_req_valid) gnt = 3'b010;
                    else if (ic_req_valid)    gnt = 3'b100;
                end
            endcase
        end
    end

    // Advance the pointer to the requester following the winner.
    always_comb begin
        rr_d = rr_q;
        if (gnt[0])      rr_d = 2'd1;
        else if (gnt[1]) rr_d = 2'd2;
        else if (gnt[2]) rr_d = 2'd0;
    end

    // Pointer register, restarting at dc_wr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 2'd0;
        else        rr_q <= rr_d;
    end
`else
    // Fixed priority: writeback first, then D-cache fill, then I-cache fill.
    always_comb begin
        gnt = 3'b000;
        if (rst_n && state_q == IDLE) begin
            if (dc_wr_req_valid)      gnt = 3'b001;
            else if (dc_rd_req_valid) gnt = 3'b010;
            else if (ic_req_valid)    gnt = 3'b100;
        end
    end
`endif

    // Address of the winning requester, before line alignment.
    always_comb begin
        sel_addr = ic_req_addr;
        if (gnt[0])      sel_addr = dc_wr_req_addr;
        else if (gnt[1]) sel_addr = dc_rd_req_addr;
    end

    // Transaction sequencing and routing of command, read and write beats.
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        cmd_write_d      = cmd_write_q;
        cmd_addr_d       = cmd_addr_q;
        cnt_d            = cnt_q;
        ic_req_ready     = gnt[2];
        dc_rd_req_ready  = gnt[1];
        dc_wr_req_ready  = gnt[0];
        ic_rdata         = '0;
        ic_rdata_valid   = 1'b0;
        dc_rdata         = '0;
        dc_rdata_valid   = 1'b0;
        dc_wr_data_ready = 1'b0;
        mem_cmd_valid    = 1'b0;
        mem_cmd_write    = 1'b0;
        mem_cmd_addr     = '0;
        mem_wdata        = '0;
        mem_wdata_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d     = CMD;
                    cmd_write_d = gnt[0];
                    owner_d     = gnt[2] ? OWN_IC : OWN_DC;
                    cmd_addr_d  = sel_addr & LINE_MASK;
                end
            end
            CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_write = cmd_write_q;
                mem_cmd_addr  = cmd_addr_q;
                if (mem_cmd_ready) begin
                    state_d = cmd_write_q ? WR_BURST : RD_BURST;
                    cnt_d   = '0;
                end
            end
            RD_BURST: begin
                if (owner_q == OWN_IC) begin
                    ic_rdata       = mem_rdata;
                    ic_rdata_valid = mem_rdata_valid;
                end else begin
                    dc_rdata       = mem_rdata;
                    dc_rdata_valid = mem_rdata_valid;
                end
                if (mem_rdata_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = IDLE;
                end
            end
            WR_BURST: begin
                mem_wdata        = dc_wr_data;
                mem_wdata_valid  = dc_wr_data_valid;
                dc_wr_data_ready = mem_wdata_ready;
                if (dc_wr_data_valid && mem_wdata_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = IDLE;
                end
            end
        endcase
    end

    // State and transaction registers; reset abandons any in-flight burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IC;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Memory must never return read beats unless a read burst is open.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(mem_rdata_valid && state_q != RD_BURST));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly downstream of the core's memory request ports: I-cache line fill, D-cache line fill and D-cache line writeback.
- Arbitrates the three requesters onto one burst-oriented memory port.
- Sequences each transaction as a command phase followed by a BURST_LEN-beat data phase, then routes read data back to the owning requester.
- Exactly one transaction is outstanding at a time.

Parameters:
ADDR_WIDTH, 26, byte address width.
DATA_WIDTH, 32, beat/word width.
BURST_LEN, 4, words per line (power of two, 2..16); matches cache BLOCK_OFFSET_WIDTH=2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
ic_req_valid  in  1  I-cache line read request
ic_req_addr  in  ADDR_WIDTH  I-cache request byte address
ic_req_ready  out  1  I-cache request accepted this cycle
ic_rdata  out  DATA_WIDTH  I-cache fill beat
ic_rdata_valid  out  1  I-cache fill beat valid
dc_rd_req_valid  in  1  D-cache line read request
dc_rd_req_addr  in  ADDR_WIDTH  D-cache read byte address
dc_rd_req_ready  out  1  D-cache read accepted
dc_rdata  out  DATA_WIDTH  D-cache fill beat
dc_rdata_valid  out  1  D-cache fill beat valid
dc_wr_req_valid  in  1  D-cache line writeback request
dc_wr_req_addr  in  ADDR_WIDTH  writeback byte address
dc_wr_req_ready  out  1  writeback accepted
dc_wr_data  in  DATA_WIDTH  writeback beat
dc_wr_data_valid  in  1  writeback beat valid
dc_wr_data_ready  out  1  writeback beat consumed
mem_cmd_valid  out  1  command valid
mem_cmd_ready  in  1  command accepted by memory
mem_cmd_write  out  1  1=write burst, 0=read burst
mem_cmd_addr  out  ADDR_WIDTH  line-aligned byte address
mem_wdata  out  DATA_WIDTH  write beat
mem_wdata_valid  out  1  write beat valid
mem_wdata_ready  in  1  memory accepts write beat
mem_rdata  in  DATA_WIDTH  read beat
mem_rdata_valid  in  1  read beat valid

Behaviour:
- States: IDLE, CMD, RD_BURST, WR_BURST. Registers: owner (IC/DC), cmd_write, cmd_addr, beat counter of width $clog2(BURST_LEN)+1.
- Reset (async): state=IDLE, counter=0, owner=IC. Every output is 0 during and after reset. An in-flight burst is abandoned; memory must be reset together with the arbiter.
- IDLE grant: priority dc_wr > dc_rd > ic (fixed; see optional feature).
  - In the same cycle, the winner's *_req_ready=1 (combinational from valids, IDLE only). Losers' ready=0.
  - cmd_addr <= winner addr with low $clog2(DATA_WIDTH/8 * BURST_LEN) bits cleared.
  - cmd_write and owner are latched; next state CMD.
- No valid in IDLE: stay IDLE, no ready.
- Requesters hold valid and addr stable until ready. A valid dropped before grant is legal and is simply not granted.
- CMD: mem_cmd_valid=1 with latched addr/write. Holds until mem_cmd_ready=1, then next state is WR_BURST (write) or RD_BURST (read), counter=0.
  - Latency: request in IDLE at cycle N gives mem_cmd_valid at N+1 at the earliest.
- RD_BURST: owner's rdata = mem_rdata; owner's rdata_valid = mem_rdata_valid. Non-owner rdata_valid=0 and rdata=0.
  - Each valid beat increments the counter.
  - On beat BURST_LEN-1: next state IDLE.
- WR_BURST: mem_wdata = dc_wr_data, mem_wdata_valid = dc_wr_data_valid, dc_wr_data_ready = mem_wdata_ready.
  - A beat transfers when valid & ready; the counter increments per transfer.
  - On transfer BURST_LEN-1: next state IDLE.
  - Gaps on either side are legal.
- dc_wr_data_ready=0 outside WR_BURST.
- mem_rdata_valid outside RD_BURST is ignored (simulation assertion flags it).
- Back-to-back transactions: one IDLE cycle between the last beat and the next grant. Minimum read transaction is BURST_LEN+2 cycles with zero memory wait.
- Counter never wraps mid-burst. It is reset to 0 on every CMD->burst transition.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: the dc_wr > dc_rd > ic priority is replaced by a rotating pointer over {dc_wr, dc_rd, ic}.
  - After a grant, the pointer moves to the requester after the winner.
  - Any requester continuously valid is granted within 3 grants.
  - Pointer resets to dc_wr.
- Undefined: fixed priority. The I-cache can starve under continuous D-side traffic, which is the accepted baseline behaviour.

Test Plan:
- Reset mid-RD_BURST after 2 of 4 beats: all outputs 0 and state IDLE immediately. After release, a fresh ic request at 0x0000123 is granted with mem_cmd_addr=0x0000120.
- ic_req_valid only, addr 0x0000040, mem_cmd_ready=1, beats 0xA0..0xA3 on consecutive cycles: ic_req_ready at N, mem_cmd_valid at N+1, ic_rdata_valid for 4 cycles with matching data, dc_rdata_valid stays 0, back to IDLE.
- All three valid in the same cycle (fixed priority): grant order dc_wr, dc_rd, ic. Write burst of 0x11,0x22,0x33,0x44 appears on mem_wdata with mem_cmd_write=1.
- Write burst with mem_wdata_ready toggling 1,0,1,0,...: exactly 4 transfers, dc_wr_data_ready mirrors mem_wdata_ready, completion after the 4th handshake only.
- mem_cmd_ready held 0 for 5 cycles: mem_cmd_valid/addr stable for 6 cycles, no data routed, no new grants.
- With ARB_ROUND_ROBIN_EN, dc_wr_valid and ic_valid held high continuously: grants alternate dc_wr, ic, dc_wr, ic.
